// File: rtl/m23a640_pkg.sv
// rtl/m23a640_pkg.sv - shared opcodes, mode encodings, depth and FSM states for the 23A640 SPI SRAM
package m23a640_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WRSR  = 8'h01;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_SEQ  = 2'b01;

    localparam int MEM_DEPTH = 8192;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_DATA_IN,
        ST_DATA_OUT,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/m23a640_mem.sv
// rtl/m23a640_mem.sv - 8192x8 array, synchronous write, combinational read
module m23a640_mem
    import m23a640_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Commit a byte on the rising edge that carries its last bit
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/m23a640_spi_sram.sv
// rtl/m23a640_spi_sram.sv - 23A640-compatible SPI SRAM slave; optional hold via M23A640_HOLD_EN
module m23a640_spi_sram
    import m23a640_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int PAGE_SIZE = 32
) (
    input  logic sck,
    input  logic rst_n,
    input  logic csb,
    output logic so,
    input  logic holdb,
    input  logic si
);

    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);

    state_t              state;
    logic [3:0]          cnt;
    logic [13:0]         sr;
    logic [ADDR_W-1:0]   addr;
    logic                is_status;
    logic                is_write;
    logic [7:0]          status;
    logic                hold;
    logic                so_en;
    logic                so_bit;
    logic [DATA_W-1:0]   mem_rdata;
    logic [7:0]          rdata;
    logic [7:0]          byte_in;
    logic [ADDR_W-1:0]   addr_in;
    logic [ADDR_W-1:0]   addr_next;
    logic [1:0]          mode;
    logic                byte_mode;
    logic                mem_we;

`ifdef M23A640_HOLD_EN
    assign hold = ~holdb & ~status[0];
`else
    logic unused_holdb;
    assign hold         = 1'b0;
    assign unused_holdb = holdb;
`endif

    assign byte_in   = {sr[6:0], si};
    assign addr_in   = {sr[ADDR_W-2:0], si};
    assign mode      = status[7:6];
    assign byte_mode = !(mode == MODE_PAGE || mode == MODE_SEQ);
    assign rdata     = is_status ? status : mem_rdata;
    assign mem_we    = (state == ST_DATA_IN) && !is_status && (cnt == 4'd7)
                       && !csb && rst_n && !hold;

    // Next address: wrap inside the page, or across the whole array
    always_comb begin
        addr_next = addr;
        if (mode == MODE_PAGE) begin
            addr_next = (addr & ~PAGE_MASK) | ((addr + 1'b1) & PAGE_MASK);
        end else if (mode == MODE_SEQ) begin
            addr_next = addr + 1'b1;
        end
    end

    // Transaction sequencer: csb high aborts at once, otherwise one step per rising sck
    always_ff @(posedge sck or posedge csb) begin
        if (csb) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (!hold) begin
            sr <= {sr[12:0], si};
            case (state)
                ST_IDLE: begin
                    state <= ST_OPCODE;
                    cnt   <= 4'd1;
                end
                ST_OPCODE: begin
                    if (cnt == 4'd7) begin
                        cnt       <= '0;
                        is_status <= 1'b0;
                        is_write  <= 1'b0;
                        case (byte_in)
                            OP_READ:  state <= ST_ADDR;
                            OP_WRITE: begin state <= ST_ADDR; is_write <= 1'b1; end
                            OP_RDSR:  begin state <= ST_DATA_OUT; is_status <= 1'b1; end
                            OP_WRSR:  begin state <= ST_DATA_IN; is_status <= 1'b1; end
                            default:  state <= ST_IGNORE;
                        endcase
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_ADDR: begin
                    if (cnt == 4'd15) begin
                        cnt  <= '0;
                        addr <= addr_in;
                        if (is_write)   state <= ST_DATA_IN;
                        else if (sr[13]) state <= ST_IGNORE;
                        else            state <= ST_DATA_OUT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_DATA_IN, ST_DATA_OUT: begin
                    if (cnt == 4'd7) begin
                        cnt <= '0;
                        if (state == ST_DATA_IN && is_status) state <= ST_IGNORE;
                        else if (!is_status) begin
                            if (byte_mode) state <= ST_IGNORE;
                            else           addr  <= addr_next;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= ST_IGNORE;
            endcase
        end
    end

    // Status register; reserved bits 5:1 always read back as zero
    always_ff @(posedge sck) begin
        if (!rst_n) begin
            status <= 8'h00;
        end else if (!csb && !hold && state == ST_DATA_IN && is_status && cnt == 4'd7) begin
            status <= {byte_in[7:6], 5'b00000, byte_in[0]};
        end
    end

    // Launch output bits on the falling edge so the master can sample on the rising edge
    always_ff @(negedge sck or posedge csb) begin
        if (csb) begin
            so_en  <= 1'b0;
            so_bit <= 1'b0;
        end else begin
            so_en  <= (state == ST_DATA_OUT);
            so_bit <= rdata[~cnt[2:0]];
        end
    end

    assign so = (so_en && state == ST_DATA_OUT && !hold) ? so_bit : 1'bz;

    m23a640_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (sck),
        .we    (mem_we),
        .addr  (addr),
        .wdata (byte_in),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_m23a640_spi_sram.sv
// tb/tb_m23a640_spi_sram.sv - randomized self-checking bench for m23a640_spi_sram
module tb_m23a640_spi_sram;

    logic sck = 1'b0;
    logic rst_n;
    logic csb;
    logic holdb;
    logic si;
    tri1  so;

    logic [7:0] tx [0:15];
    logic [7:0] rx [0:15];
    logic [7:0] wdat [0:7];
    int         rst_at;
    int         n_tests;
    int         n_fail;

    logic [7:0] ref_mem [0:8191];
    bit         known [0:8191];
    logic [7:0] ref_status;

    m23a640_spi_sram dut (
        .sck   (sck),
        .rst_n (rst_n),
        .csb   (csb),
        .so    (so),
        .holdb (holdb),
        .si    (si)
    );

    always #5 sck = ~sck;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input int base, input int k);
        case (ref_status[7:6])
            2'b01:   return (base + k) % 8192;
            2'b10:   return (base / 32) * 32 + ((base % 32) + k) % 32;
            default: return base;
        endcase
    endfunction

    function automatic int span(input int n);
        return (ref_status[7:6] == 2'b01 || ref_status[7:6] == 2'b10) ? n : 1;
    endfunction

    task automatic clear_tx();
        for (int i = 0; i < 16; i++) tx[i] = 8'h00;
    endtask

    task automatic xfer(input int nbits);
        @(negedge sck);
        csb = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            si    = tx[i/8][7-(i%8)];
            rst_n = (i == rst_at) ? 1'b0 : 1'b1;
            #4;
            rx[i/8][7-(i%8)] = so;
            @(posedge sck);
            @(negedge sck);
        end
        csb    = 1'b1;
        rst_n  = 1'b1;
        rst_at = -1;
        @(negedge sck);
    endtask

    task automatic spi_write(input logic [15:0] a, input int n);
        int base;
        clear_tx();
        tx[0] = 8'h02; tx[1] = a[15:8]; tx[2] = a[7:0];
        for (int k = 0; k < n; k++) tx[3+k] = wdat[k];
        xfer(24 + 8*n);
        base = int'(a[12:0]);
        for (int k = 0; k < span(n); k++) begin
            ref_mem[idx_of(base, k)] = wdat[k];
            known[idx_of(base, k)]   = 1'b1;
        end
    endtask

    task automatic wr1(input logic [15:0] a, input logic [7:0] d);
        wdat[0] = d;
        spi_write(a, 1);
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input int n);
        int base;
        int idx;
        clear_tx();
        tx[0] = 8'h03; tx[1] = a[15:8]; tx[2] = a[7:0];
        xfer(24 + 8*n);
        base = int'(a[12:0]);
        for (int k = 0; k < n; k++) begin
            if (a[14] || k >= span(n)) begin
                check_eq($sformatf("%s_%h_%0d", tag, a, k), rx[3+k], 8'hFF);
            end else begin
                idx = idx_of(base, k);
                if (known[idx]) check_eq($sformatf("%s_%h_%0d", tag, a, k), rx[3+k], ref_mem[idx]);
            end
        end
    endtask

    task automatic wrsr(input logic [7:0] v);
        clear_tx();
        tx[0] = 8'h01; tx[1] = v;
        xfer(16);
        ref_status = {v[7:6], 5'b00000, v[0]};
    endtask

    task automatic rdsr_check(input string tag);
        clear_tx();
        tx[0] = 8'h05;
        xfer(16);
        check_eq(tag, rx[1], ref_status);
    endtask

    initial begin
        logic [15:0] ra;
        int          rn;
        n_tests = 0; n_fail = 0; rst_at = -1;
        csb = 1'b1; rst_n = 1'b0; holdb = 1'b1; si = 1'b0;
        ref_status = 8'h00;
        for (int i = 0; i < 8192; i++) begin known[i] = 1'b0; ref_mem[i] = 8'h00; end
        repeat (3) @(negedge sck);
        check_eq("reset_so", {7'd0, so}, 8'h01);
        rst_n = 1'b1;
        rdsr_check("reset_status");

        wr1(16'h0001, 8'h01); wr1(16'h0002, 8'h12); wr1(16'h0003, 8'h13);
        wr1(16'h0004, 8'h34); wr1(16'h0005, 8'h45);
        wr1(16'h1001, 8'h56); wr1(16'h1002, 8'h67); wr1(16'h1003, 8'h78);
        wr1(16'h1004, 8'h89); wr1(16'h1005, 8'h9A);
        wr1(16'h0003, 8'h23);
        for (int i = 1; i <= 5; i++) begin
            rd_check("rb_lo", 16'h0000 + 16'(i), 1);
            rd_check("rb_hi", 16'h1000 + 16'(i), 1);
        end
        rd_check("rb_0003", 16'h0003, 1);
        check_eq("plan_0003", rx[3], 8'h23);
        rd_check("rb_1005", 16'h1005, 1);
        check_eq("plan_1005", rx[3], 8'h9A);

        wr1(16'h0001, 8'h10); wr1(16'h0002, 8'h21); wr1(16'h0003, 8'h32);
        for (int i = 1; i <= 5; i++) rd_check("ovr", 16'h0000 + 16'(i), 1);
        rd_check("ovr_0004", 16'h0004, 1);
        check_eq("plan_0004", rx[3], 8'h34);

        wr1(16'h0001, 8'h34); wr1(16'h0002, 8'h12);
        clear_tx();
        tx[0] = 8'h02; tx[1] = 8'h00; tx[2] = 8'h02; tx[3] = 8'h56;
        xfer(31);
        rd_check("abort", 16'h0002, 1);
        check_eq("plan_abort", rx[3], 8'h12);
        wr1(16'h0003, 8'h78);
        rd_check("after_abort", 16'h0003, 1);

        rd_check("alias_8001", 16'h8001, 1);
        rd_check("unmapped_4002", 16'h4002, 1);
        wr1(16'h4001, 8'h34);
        rd_check("alias_w0001", 16'h0001, 1);
        rd_check("alias_w8001", 16'h8001, 1);

        clear_tx();
        tx[0] = 8'hAB; tx[1] = 8'h00; tx[2] = 8'h01;
        xfer(32);
        check_eq("unknown_op", rx[3], 8'hFF);

        wrsr(8'h40);
        rdsr_check("rdsr_seq");
        wdat[0] = 8'hAA; wdat[1] = 8'hBB; wdat[2] = 8'hCC;
        spi_write(16'h1FFF, 3);
        rd_check("seq_a", 16'h1FFF, 1);
        rd_check("seq_b", 16'h0000, 1);
        rd_check("seq_c", 16'h0001, 1);
        rd_check("seq_burst", 16'h1FFF, 3);
        wrsr(8'h80);
        wdat[0] = 8'hD1; wdat[1] = 8'hD2; wdat[2] = 8'hD3; wdat[3] = 8'hD4;
        spi_write(16'h003E, 4);
        rd_check("page_burst", 16'h003E, 4);
        rd_check("page_wrap", 16'h0020, 1);
        wrsr(8'hFF);
        rdsr_check("rdsr_mask");
        rd_check("mode11", 16'h1001, 2);
        wrsr(8'h00);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                wrsr(8'($urandom));
                rdsr_check("rnd_rdsr");
            end
            ra = 16'($urandom);
            rn = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < rn; k++) wdat[k] = 8'($urandom);
                spi_write(ra, rn);
                ra[14] = 1'b0;
            end
            rd_check("rnd_rd", ra, rn);
        end

        wrsr(8'h00);
        wr1(16'h0001, 8'hA5);
        clear_tx();
        tx[0] = 8'h03; tx[1] = 8'h00; tx[2] = 8'h01;
        rst_at = 26;
        xfer(40);
        ref_status = 8'h00;
        check_eq("rst_partial", rx[3], {ref_mem[1][7:5], 5'b11111});
        check_eq("rst_so_z", rx[4], 8'hFF);
        rdsr_check("rst_status");
        rd_check("rst_retain", 16'h0001, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m23a640_spi_sram.md
Name: m23a640_spi_sram

Overview:
- Behavioural and synthesisable model of a 64 Kbit (8192 x 8) SPI serial SRAM, compatible with the 23A640.
- Sits on a board-level SPI bus as a slave and serves byte, page and sequential reads and writes.
- The SPI serial clock is the block's only clock.

Parameters:
- ADDR_W, 13, number of significant address bits (memory depth = 2^ADDR_W).
- DATA_W, 8, word width.
- PAGE_SIZE, 32, page length in bytes for page mode.

Ports:
- sck  in  1  SPI serial clock and the block's only clock. si is sampled on the rising edge; so changes on the falling edge.
- rst_n  in  1  Reset, synchronous to rising sck, active-low.
- csb  in  1  Chip select, active-low.
- so  out  1  Serial data out, tri-state; 'z' whenever the block is not driving data.
- holdb  in  1  Hold input, active-low.
- si  in  1  Serial data in, MSB first.

Behaviour:
- Reset (rst_n=0 at rising sck):
  - FSM goes to IDLE, bit counter clears, so='z'.
  - Status register = 8'h00 (byte mode).
  - Memory contents are not cleared; they power up as X.
- csb=1:
  - Asynchronously forces IDLE, clears the bit counter and tri-states so, independent of rst_n.
  - No sck edge is needed between transactions.
  - Rising sck edges while csb=1 are ignored.
- Frame: 8-bit opcode, MSB first, then opcode-specific fields.
- FSM states: IDLE -> OPCODE -> ADDR (16 bits) -> DATA_IN / DATA_OUT; opcodes without an address go straight to their data phase; any unknown opcode -> IGNORE until csb=1.
- Opcodes:
  - READ 8'h03: 16-bit address (MSB first) -> DATA_OUT.
  - WRITE 8'h02: 16-bit address -> DATA_IN.
  - RDSR 8'h05: status byte shifted out.
  - WRSR 8'h01: 8 bits written to the status register.
- Address map:
  - Memory index = addr[12:0]; addr[15] and addr[13] are ignored, so 16'h8001 aliases 16'h0001.
  - addr[14] is ignored for WRITE, so 16'h4001 writes 16'h0001.
  - READ with addr[14]=1 is an unmapped read window: so stays 'z' for the entire transaction.
- READ timing:
  - Address bit 0 is sampled on rising edge 24.
  - The next falling edge drives data[7]; each following falling edge drives the next lower bit.
  - The master samples so just before each rising edge.
- WRITE commit:
  - A byte is written to memory on the rising edge that samples its bit 0 (edge 32 for the first byte).
  - If csb rises before that edge, the write is aborted and memory is unchanged.
- Mode, status[7:6]:
  - 00 byte: after one data byte, further clocks are ignored and so='z'.
  - 10 page: address auto-increments and wraps within the 32-byte page.
  - 01 sequential: address auto-increments and wraps 13'h1FFF -> 13'h0000.
  - 11: behaves as byte mode.
- Status register: bit0 = HOLD disable; bits 5:1 read as 0.
- RDSR: status MSB is driven on the falling edge after opcode bit 0.
- WRSR: the status register updates on rising edge 16.

Optional Feature:
- Macro M23A640_HOLD_EN.
- Defined:
  - holdb=0 (while sck=0 and status[0]=0) pauses the transaction: sck edges are ignored and so='z'.
  - holdb=1 resumes exactly where the transaction left off.
- Undefined: holdb is ignored and status[0] is stored only.

Decomposition:
- Package m23a640_pkg holds:
  - Opcode constants: OP_READ, OP_WRITE, OP_RDSR, OP_WRSR.
  - Mode encodings: MODE_BYTE, MODE_PAGE, MODE_SEQ.
  - MEM_DEPTH.
  - FSM state enum.
- One sub-module, m23a640_mem: 8192x8 synchronous-write, combinational-read array.

Test Plan:
- Write then read-back: write 16'h0001..0005 and 16'h1001..1005 (16'h0003 written twice, 8'h13 then 8'h23) -> each read returns the last value written, e.g. 16'h0003=8'h23 and 16'h1005=8'h9A.
- Overwrite: rewrite 16'h0001..0003 with 8'h10, 8'h21, 8'h32 -> those addresses read the new values; 16'h0004=8'h34 and 16'h0005=8'h45 are unchanged.
- Aborted write: write 16'h0001=8'h34; a write of 8'h56 to 16'h0002 with csb raised after data bit 1 -> 16'h0002 still reads 8'h12; a following write of 16'h0003=8'h78 succeeds.
- Aliasing:
  - Reading 16'h8001 returns the data at 16'h0001.
  - Reading 16'h4002 returns 8'hzz.
  - Writing 16'h4001=8'h34 makes both 16'h0001 and 16'h8001 read 8'h34.
- Modes:
  - WRSR 8'h40 (sequential) and a 3-byte write at 13'h1FFF -> bytes land at 13'h1FFF, 13'h0000 and 13'h0001.
  - RDSR returns 8'h40.
- Reset: rst_n=0 for one sck edge mid-READ -> so='z', status reads 8'h00, and previously written memory is retained.
